uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters, 2..8.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16*CLOCK_RATE/BAUD_RATE: watchdog limit per byte.
REQ-003 SHALL have ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high.
- req  input  NUM_REQ  per-requester send request, level.
- reqData  input  8*NUM_REQ  packed bytes; requester i uses bits [8i+7:8i].
- txBusy  input  1  transmitter busy.
- txDone  input  1  transmitter single-cycle byte-complete pulse.
- grant  output  NUM_REQ  one-hot, single-cycle; byte of that requester captured.
- txStart  output  1  single-cycle start pulse to transmitter.
- txData  output  8  byte to transmitter.
- servedId  output  3  index of requester currently served.
- busy  output  1  high whenever not IDLE.
- done  output  1  single-cycle pulse, byte completed.
- timeoutErr  output  1  single-cycle pulse, watchdog expired.

Function
REQ-004 SHALL implement FSM states IDLE, SEND, WAIT_DONE; any other encoding SHALL go to IDLE next cycle.
REQ-005 In IDLE with |req=1 and txBusy=0, SHALL select the winner round-robin from pointer (last+1) mod NUM_REQ upward, wrapping.
REQ-006 On selection (registered), SHALL pulse grant[winner] for 1 cycle, latch reqData byte into txData, set servedId=winner, enter SEND.
REQ-007 In IDLE with txBusy=1, SHALL issue no grant regardless of req.
REQ-008 In SEND, SHALL pulse txStart for exactly 1 cycle, clear watchdog counter, enter WAIT_DONE.
REQ-009 Latency: req rising in cycle N (IDLE, txBusy=0) -> grant in N+1 -> txStart in N+2.
REQ-010 txData and servedId SHALL remain stable from grant until return to IDLE.
REQ-011 In WAIT_DONE, txDone=1 SHALL pulse done, set last=servedId, return to IDLE.
REQ-012 In WAIT_DONE, watchdog counter SHALL increment each cycle; reaching TIMEOUT_CYCLES-1 without txDone SHALL pulse timeoutErr, set last=servedId, return to IDLE.
REQ-013 txDone and timeout in the same cycle: txDone wins; done pulses, timeoutErr does not.
REQ-014 txDone outside WAIT_DONE SHALL be ignored.
REQ-015 Requester deasserting req before its grant SHALL not be served; requesters SHALL hold req and data until grant.
REQ-016 Requester keeping req high after grant SHALL be treated as a new request; it is re-eligible only after all other active requesters are served.
REQ-017 Back-to-back: return to IDLE then re-arbitration SHALL add exactly 1 idle cycle between consecutive grants.
REQ-018 Watchdog counter width SHALL be $clog2(TIMEOUT_CYCLES); no wrap before timeout.

Reset
REQ-019 On reset: state=IDLE; grant=0, txStart=0, txData=0, servedId=0, busy=0, done=0, timeoutErr=0, watchdog=0.
REQ-020 On reset: last=NUM_REQ-1, so requester 0 has highest priority first.
REQ-021 Reset mid-transfer SHALL abort immediately; no done or timeoutErr pulse is generated.

Structure
REQ-022 State encodings, CLOCK_RATE, BAUD_RATE SHALL come from the shared UART state/constant include, alongside receiver states.
REQ-023 Round-robin selection SHALL be one sub-module rr_picker (inputs req, last; outputs one-hot winner, index, valid), purely combinational.

Verification
REQ-024 Bench SHALL cover:
- Single req[2]=1, reqData byte2=0xA5, txBusy=0 -> grant=4'b0100 at N+1, txStart at N+2, txData=0xA5; txDone -> done 1 cycle, busy low next cycle.
- req=4'b1111 held, txDone returned 10 cycles after each txStart -> grant order 0,1,2,3,0; servedId matches.
- txBusy=1 in IDLE with req=4'b0001 -> no grant until txBusy=0, grant next cycle.
- No txDone after txStart -> timeoutErr exactly at TIMEOUT_CYCLES-1 cycles after entering WAIT_DONE, then next requester served.
- txDone coincident with timeout cycle -> done=1, timeoutErr=0.
- reset asserted in WAIT_DONE -> all outputs 0, next arbitration with req=4'b1010 grants requester 1.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared UART constants and state encodings for the transmit arbiter and the receiver.
package uart_tx_arbiter_pkg;

  localparam int CLOCK_RATE = 50_000_000;
  localparam int BAUD_RATE  = 115_200;

  typedef logic [1:0] fsm_state_t;

  // Transmit arbiter states
  localparam fsm_state_t TX_IDLE      = 2'd0;
  localparam fsm_state_t TX_SEND      = 2'd1;
  localparam fsm_state_t TX_WAIT_DONE = 2'd2;

  // Receiver states
  localparam fsm_state_t RX_IDLE  = 2'd0;
  localparam fsm_state_t RX_START = 2'd1;
  localparam fsm_state_t RX_DATA  = 2'd2;
  localparam fsm_state_t RX_STOP  = 2'd3;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: scans upward from (last+1) mod NUM_REQ, wrapping,
// and reports the first active requester as one-hot plus index.
module rr_picker #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         last,
  output logic [NUM_REQ-1:0] winner,
  output logic [2:0]         index,
  output logic               valid
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IW-1:0] candIdx;

  always_comb begin
    winner  = '0;
    index   = '0;
    valid   = 1'b0;
    candIdx = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      candIdx = IW'((int'(last) + i) % NUM_REQ);
      if (!valid && req[candIdx]) begin
        valid           = 1'b1;
        winner[candIdx] = 1'b1;
        index           = 3'(candIdx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding bytes from NUM_REQ requesters to a single UART
// transmitter, with a per-byte watchdog that abandons a transfer the transmitter never finishes.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 16 * CLOCK_RATE / BAUD_RATE
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   reqData,
  input  logic                   txBusy,
  input  logic                   txDone,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   txStart,
  output logic [7:0]             txData,
  output logic [2:0]             servedId,
  output logic                   busy,
  output logic                   done,
  output logic                   timeoutErr
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);

  logic [1:0]         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               txStart_q, txStart_d;
  logic [7:0]         txData_q, txData_d;
  logic [2:0]         servedId_q, servedId_d;
  logic [2:0]         last_q, last_d;
  logic [CW-1:0]      wdog_q, wdog_d;

  logic [NUM_REQ-1:0] pickOneHot;
  logic [2:0]         pickIdx;
  logic               pickValid;
  logic               wdogExpired;

  rr_picker #(
    .NUM_REQ(NUM_REQ)
  ) uPicker (
    .req   (req),
    .last  (last_q),
    .winner(pickOneHot),
    .index (pickIdx),
    .valid (pickValid)
  );

  assign wdogExpired = (wdog_q == CW'(TIMEOUT_CYCLES - 1));

  // done and timeoutErr are decoded from the current WAIT_DONE cycle so that a
  // txDone arriving on the expiry cycle suppresses the timeout.
  always_comb begin
    state_d    = state_q;
    grant_d    = '0;
    txStart_d  = 1'b0;
    txData_d   = txData_q;
    servedId_d = servedId_q;
    last_d     = last_q;
    wdog_d     = wdog_q;
    done       = 1'b0;
    timeoutErr = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (pickValid && !txBusy) begin
          grant_d    = pickOneHot;
          txData_d   = reqData[8*pickIdx +: 8];
          servedId_d = pickIdx;
          state_d    = TX_SEND;
        end
      end
      TX_SEND: begin
        txStart_d = 1'b1;
        wdog_d    = '0;
        state_d   = TX_WAIT_DONE;
      end
      TX_WAIT_DONE: begin
        if (txDone) begin
          done    = 1'b1;
          last_d  = servedId_q;
          state_d = TX_IDLE;
        end else if (wdogExpired) begin
          timeoutErr = 1'b1;
          last_d     = servedId_q;
          state_d    = TX_IDLE;
        end else begin
          wdog_d = wdog_q + CW'(1);
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= TX_IDLE;
      grant_q    <= '0;
      txStart_q  <= 1'b0;
      txData_q   <= '0;
      servedId_q <= '0;
      last_q     <= 3'(NUM_REQ - 1);
      wdog_q     <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      txStart_q  <= txStart_d;
      txData_q   <= txData_d;
      servedId_q <= servedId_d;
      last_q     <= last_d;
      wdog_q     <= wdog_d;
    end
  end

  assign grant    = grant_q;
  assign txStart  = txStart_q;
  assign txData   = txData_q;
  assign servedId = servedId_q;
  assign busy     = (state_q != TX_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected grants are queued as requests are
// driven and matched by a monitor whenever the arbiter issues a grant.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 16;

  logic        clk     = 1'b0;
  logic        reset   = 1'b1;
  logic [3:0]  req     = '0;
  logic [31:0] reqData = '0;
  logic        txBusy  = 1'b0;
  logic        txDone  = 1'b0;
  logic [3:0]  grant;
  logic        txStart;
  logic [7:0]  txData;
  logic [2:0]  servedId;
  logic        busy;
  logic        done;
  logic        timeoutErr;

  typedef struct packed {
    logic [3:0] grant;
    logic [2:0] id;
    logic [7:0] data;
  } expGrant_t;

  expGrant_t expQ[$];
  expGrant_t head;
  int checkCount = 0;
  int passCount  = 0;
  int cyc;
  int cnt;

  uart_tx_arbiter #(
    .NUM_REQ       (NUM_REQ),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .reqData   (reqData),
    .txBusy    (txBusy),
    .txDone    (txDone),
    .grant     (grant),
    .txStart   (txStart),
    .txData    (txData),
    .servedId  (servedId),
    .busy      (busy),
    .done      (done),
    .timeoutErr(timeoutErr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic [3:0] reqVal, input logic [31:0] dataVal);
    reqData = dataVal;
    req     = reqVal;
  endtask

  task automatic pushExp(input int id);
    expGrant_t e;
    e.grant = 4'(1 << id);
    e.id    = 3'(id);
    e.data  = reqData[8*id +: 8];
    expQ.push_back(e);
  endtask

  task automatic waitGrant(output int cycles);
    int k;
    k = 0;
    cycles = 0;
    while (cycles == 0 && k < 40) begin
      k++;
      @(negedge clk);
      if (grant !== '0) cycles = k;
    end
    if (cycles == 0) checkOutput("grantTimeout", 32'd0, 32'd1);
  endtask

  // Expects txStart on the next negedge, then answers txDone doneDelay cycles later.
  task automatic serveTx(input int doneDelay, input logic [7:0] expData);
    @(negedge clk);
    checkOutput("txStart", 32'(txStart), 32'd1);
    checkOutput("busySend", 32'(busy), 32'd1);
    @(negedge clk);
    checkOutput("txStartPulse", 32'(txStart), 32'd0);
    repeat (doneDelay - 1) @(negedge clk);
    txDone = 1'b1;
    #1;
    checkOutput("done", 32'(done), 32'd1);
    checkOutput("noTimeoutOnDone", 32'(timeoutErr), 32'd0);
    checkOutput("txDataHold", 32'(txData), 32'(expData));
    @(negedge clk);
    txDone = 1'b0;
    checkOutput("busyLowAfterDone", 32'(busy), 32'd0);
    checkOutput("donePulse", 32'(done), 32'd0);
  endtask

  // Lets the watchdog run out; with coincide set, txDone lands on the expiry cycle.
  task automatic serveTimeout(input bit coincide);
    int early;
    early = 0;
    @(negedge clk);
    checkOutput("txStartTo", 32'(txStart), 32'd1);
    for (int k = 1; k <= TIMEOUT - 2; k++) begin
      @(negedge clk);
      if (timeoutErr !== 1'b0 || done !== 1'b0) early++;
    end
    @(negedge clk);
    if (coincide) begin
      txDone = 1'b1;
      #1;
      checkOutput("coincideDone", 32'(done), 32'd1);
      checkOutput("coincideNoTimeout", 32'(timeoutErr), 32'd0);
    end else begin
      checkOutput("timeoutErr", 32'(timeoutErr), 32'd1);
      checkOutput("timeoutNoDone", 32'(done), 32'd0);
    end
    checkOutput("earlyPulse", 32'(early), 32'd0);
    @(negedge clk);
    txDone = 1'b0;
    checkOutput("busyLowAfterTimeout", 32'(busy), 32'd0);
    checkOutput("timeoutPulse", 32'(timeoutErr), 32'd0);
  endtask

  // Scoreboard monitor: every grant must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && grant !== '0) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedGrant", 32'(grant), 32'd0);
      end else begin
        head = expQ.pop_front();
        checkOutput("grant", 32'(grant), 32'(head.grant));
        checkOutput("servedId", 32'(servedId), 32'(head.id));
        checkOutput("txData", 32'(txData), 32'(head.data));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL globalTimeout: observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rstGrant", 32'(grant), 32'd0);
    checkOutput("rstTxStart", 32'(txStart), 32'd0);
    checkOutput("rstTxData", 32'(txData), 32'd0);
    checkOutput("rstServedId", 32'(servedId), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstDone", 32'(done), 32'd0);
    checkOutput("rstTimeout", 32'(timeoutErr), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    txDone = 1'b1;
    #1;
    checkOutput("doneIgnoredIdle", 32'(done), 32'd0);
    @(negedge clk);
    txDone = 1'b0;
    checkOutput("busyIdle", 32'(busy), 32'd0);

    // All four requesting: fair rotation starting at requester 0
    applyStimulus(4'b1111, 32'h13121110);
    pushExp(0); pushExp(1); pushExp(2); pushExp(3); pushExp(0);
    for (int i = 0; i < 5; i++) begin
      waitGrant(cyc);
      checkOutput((i == 0) ? "grantLatency" : "backToBack", 32'(cyc), 32'd1);
      if (i == 4) req = 4'b0000;
      serveTx(10, 8'(8'h10 + ((i == 4) ? 0 : i)));
    end

    applyStimulus(4'b0100, 32'h00A50000);
    pushExp(2);
    waitGrant(cyc);
    checkOutput("singleLatency", 32'(cyc), 32'd1);
    checkOutput("singleGrant", 32'(grant), 32'b0100);
    req = 4'b0000;
    serveTx(5, 8'hA5);

    txBusy = 1'b1;
    applyStimulus(4'b0001, 32'h0000005A);
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (grant !== '0) cnt++;
    end
    checkOutput("noGrantWhileTxBusy", 32'(cnt), 32'd0);
    pushExp(0);
    txBusy = 1'b0;
    waitGrant(cyc);
    checkOutput("grantAfterTxBusy", 32'(cyc), 32'd1);
    req = 4'b0000;
    serveTx(4, 8'h5A);

    applyStimulus(4'b0110, 32'h00C3B200);
    pushExp(1); pushExp(2);
    waitGrant(cyc);
    serveTimeout(1'b0);
    waitGrant(cyc);
    checkOutput("nextAfterTimeout", 32'(cyc), 32'd1);
    req = 4'b0000;
    serveTimeout(1'b1);

    applyStimulus(4'b1000, 32'hD4000000);
    pushExp(3);
    waitGrant(cyc);
    req = 4'b0000;
    @(negedge clk);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("midRstGrant", 32'(grant), 32'd0);
    checkOutput("midRstTxStart", 32'(txStart), 32'd0);
    checkOutput("midRstTxData", 32'(txData), 32'd0);
    checkOutput("midRstServedId", 32'(servedId), 32'd0);
    checkOutput("midRstBusy", 32'(busy), 32'd0);
    checkOutput("midRstDone", 32'(done), 32'd0);
    checkOutput("midRstTimeout", 32'(timeoutErr), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    repeat (TIMEOUT + 2) begin
      @(negedge clk);
      if (done !== 1'b0 || timeoutErr !== 1'b0 || busy !== 1'b0) cnt++;
    end
    checkOutput("noPulseAfterReset", 32'(cnt), 32'd0);

    applyStimulus(4'b1010, 32'h77006E00);
    pushExp(1);
    waitGrant(cyc);
    checkOutput("grantAfterReset", 32'(grant), 32'b0010);
    req = 4'b0000;
    serveTx(3, 8'h6E);

    repeat (3) @(negedge clk);
    checkOutput("scoreboardDrained", 32'(expQ.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
